// File: rtl/ext_tag_allocator_pkg.sv
// Shared tag-width constants for the DMA read path.
// Holds internal (SIG_TAG_W) and external PCIe tag widths side by side.
// Helper converts a tag width into a pool size.
package ext_tag_allocator_pkg;

  // Internal tag width used by the requesters and the completion router.
  localparam int SIG_TAG_W = 6;

  // External PCIe tag width; the pool holds 2**EXT_TAG_W tags.
  localparam int EXT_TAG_W = 5;

  // Number of tags addressable by a tag field of the given width.
  function automatic int tag_pool_size(input int tag_w);
    return 1 << tag_w;
  endfunction

endpackage

// File: rtl/ext_tag_allocator_tag_free_encoder.sv
// Purpose: lowest-index free-tag picker over the inverted busy bitmap.
// Latency: purely combinational, no state.
// Backpressure: none; any_free low means the pool is exhausted.
module tag_free_encoder #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] free_vec,
  output logic [W-1:0] idx,
  output logic         any_free
);

  // Scan from the top down so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        idx      = W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_tag_allocator.sv
// Purpose: allocates PCIe external tags, maps them to internal tags, frees on final completion.
// Latency: alloc pulse -> EXT_TAG one cycle later; completion tag -> internal tag one cycle later.
// Backpressure: TAGS_AVAIL low blocks the arbiter; an alloc while full is dropped and flags TAG_ERR.
module ext_tag_allocator
  import ext_tag_allocator_pkg::*;
#(
  parameter int C_TAG_WIDTH     = EXT_TAG_W,
  parameter int C_INT_TAG_WIDTH = SIG_TAG_W
) (
  input  logic                       CLK,
  input  logic                       RST_IN_N,
  input  logic [C_INT_TAG_WIDTH-1:0] INT_TAG,
  input  logic                       INT_TAG_VALID,
  output logic [C_TAG_WIDTH-1:0]     EXT_TAG,
  output logic                       EXT_TAG_VALID,
  input  logic [C_TAG_WIDTH-1:0]     CPL_TAG,
  input  logic                       CPL_TAG_VALID,
  input  logic                       CPL_DONE,
  output logic [C_INT_TAG_WIDTH-1:0] CPL_INT_TAG,
  output logic                       CPL_INT_TAG_VALID,
  output logic                       TAGS_AVAIL,
  output logic [C_TAG_WIDTH:0]       TAGS_OUTSTANDING,
  output logic                       TAG_ERR
);

  localparam int                   POOL     = tag_pool_size(C_TAG_WIDTH);
  localparam int                   CNT_W    = C_TAG_WIDTH + 1;
  localparam logic [CNT_W-1:0]     POOL_CNT = CNT_W'(POOL);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  // Busy bitmap: bit i set while external tag i is in flight.
  logic [POOL-1:0]            busy_q, busy_d;

  // ext -> int mapping; contents are meaningless for idle tags, so no reset.
  logic [C_INT_TAG_WIDTH-1:0] map_q [POOL];

  logic [C_TAG_WIDTH-1:0]     ext_tag_q, ext_tag_d;
  logic                       ext_tag_vld_q, ext_tag_vld_d;
  logic [C_INT_TAG_WIDTH-1:0] cpl_int_tag_q, cpl_int_tag_d;
  logic                       cpl_int_tag_vld_q, cpl_int_tag_vld_d;
  logic                       tags_avail_q, tags_avail_d;
  logic [CNT_W-1:0]           outstanding_q, outstanding_d;
  logic                       tag_err_q, tag_err_d;

  logic [C_TAG_WIDTH-1:0]     alloc_idx;
  logic                       any_free;
  logic                       alloc_ok;
  logic                       free_req;
  logic                       free_ok;
  logic                       cpl_tag_busy;

  // The encoder only sees the bitmap from the previous edge, so a tag being
  // freed this cycle can never be handed out in the same cycle.
  tag_free_encoder #(
    .N (POOL),
    .W (C_TAG_WIDTH)
  ) u_free_enc (
    .free_vec (~busy_q),
    .idx      (alloc_idx),
    .any_free (any_free)
  );

  assign cpl_tag_busy = busy_q[CPL_TAG];
  assign alloc_ok     = INT_TAG_VALID & any_free;
  assign free_req     = CPL_TAG_VALID & CPL_DONE;
  assign free_ok      = free_req & cpl_tag_busy;

  // Next-state for bitmap, counter, error flag and the two output pipes.
  always_comb begin
    busy_d = busy_q;
    if (free_ok) begin
      busy_d[CPL_TAG] = 1'b0;
    end
    if (alloc_ok) begin
      busy_d[alloc_idx] = 1'b1;
    end

    // Alloc and free together cancel out.
    outstanding_d = outstanding_q;
    case ({alloc_ok, free_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase

    tags_avail_d = (outstanding_d < POOL_CNT);

    // Sticky until reset: alloc with no free tag, or free of an idle tag.
    tag_err_d = tag_err_q
              | (INT_TAG_VALID & ~any_free)
              | (free_req & ~cpl_tag_busy);

    // EXT_TAG holds its last value between pulses.
    ext_tag_vld_d = alloc_ok;
    ext_tag_d     = alloc_ok ? alloc_idx : ext_tag_q;

    // Registered read port; an alloc writing the same entry this cycle is
    // not visible until the following lookup.
    cpl_int_tag_vld_d = CPL_TAG_VALID;
    cpl_int_tag_d     = CPL_TAG_VALID ? map_q[CPL_TAG] : cpl_int_tag_q;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_IN_N) begin
      busy_q            <= '0;
      outstanding_q     <= '0;
      tags_avail_q      <= 1'b1;
      tag_err_q         <= 1'b0;
      ext_tag_q         <= '0;
      ext_tag_vld_q     <= 1'b0;
      cpl_int_tag_q     <= '0;
      cpl_int_tag_vld_q <= 1'b0;
    end else begin
      busy_q            <= busy_d;
      outstanding_q     <= outstanding_d;
      tags_avail_q      <= tags_avail_d;
      tag_err_q         <= tag_err_d;
      ext_tag_q         <= ext_tag_d;
      ext_tag_vld_q     <= ext_tag_vld_d;
      cpl_int_tag_q     <= cpl_int_tag_d;
      cpl_int_tag_vld_q <= cpl_int_tag_vld_d;
    end
  end

  // Single write port into the map RAM, driven by allocation.
  always_ff @(posedge CLK) begin
    if (alloc_ok) begin
      map_q[alloc_idx] <= INT_TAG;
    end
  end

  assign EXT_TAG           = ext_tag_q;
  assign EXT_TAG_VALID     = ext_tag_vld_q;
  assign CPL_INT_TAG       = cpl_int_tag_q;
  assign CPL_INT_TAG_VALID = cpl_int_tag_vld_q;
  assign TAGS_AVAIL        = tags_avail_q;
  assign TAGS_OUTSTANDING  = outstanding_q;
  assign TAG_ERR           = tag_err_q;

endmodule

// File: tb/tb_ext_tag_allocator.sv
// Purpose: directed and randomized checking of ext_tag_allocator against a tag-pool model.
// Latency: every step drives inputs, clocks once, then compares outputs 1 time unit later.
// Backpressure: none from the bench; full-pool allocs are issued deliberately.
module tb_ext_tag_allocator;

  localparam int TW = 5;
  localparam int IW = 6;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] int_tag;
  logic          int_tag_vld;
  logic [TW-1:0] ext_tag;
  logic          ext_tag_vld;
  logic [TW-1:0] cpl_tag;
  logic          cpl_tag_vld;
  logic          cpl_done;
  logic [IW-1:0] cpl_int_tag;
  logic          cpl_int_tag_vld;
  logic          tags_avail;
  logic [TW:0]   tags_outstanding;
  logic          tag_err;

  ext_tag_allocator #(
    .C_TAG_WIDTH     (TW),
    .C_INT_TAG_WIDTH (IW)
  ) dut (
    .CLK               (clk),
    .RST_IN_N          (rst_n),
    .INT_TAG           (int_tag),
    .INT_TAG_VALID     (int_tag_vld),
    .EXT_TAG           (ext_tag),
    .EXT_TAG_VALID     (ext_tag_vld),
    .CPL_TAG           (cpl_tag),
    .CPL_TAG_VALID     (cpl_tag_vld),
    .CPL_DONE          (cpl_done),
    .CPL_INT_TAG       (cpl_int_tag),
    .CPL_INT_TAG_VALID (cpl_int_tag_vld),
    .TAGS_AVAIL        (tags_avail),
    .TAGS_OUTSTANDING  (tags_outstanding),
    .TAG_ERR           (tag_err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: which tags are in flight, what they map to, error flag.
  bit          m_busy  [N];
  logic [IW-1:0] m_map [N];
  bit          m_known [N];
  int          m_cnt;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i]  = 1'b0;
      m_known[i] = 1'b0;
    end
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic drive_idle();
    int_tag     = '0;
    int_tag_vld = 1'b0;
    cpl_tag     = '0;
    cpl_tag_vld = 1'b0;
    cpl_done    = 1'b0;
  endtask

  // One-cycle reset pulse followed by a check of every reset value.
  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_ext_tag", ext_tag, 0);
    check("rst_ext_vld", ext_tag_vld, 0);
    check("rst_cpl_int", cpl_int_tag, 0);
    check("rst_cpl_vld", cpl_int_tag_vld, 0);
    check("rst_avail", tags_avail, 1);
    check("rst_outstanding", tags_outstanding, 0);
    check("rst_err", tag_err, 0);
    rst_n = 1'b1;
  endtask

  // Apply one cycle of stimulus, predict from the model, compare after the edge.
  task automatic step(input bit a, input logic [IW-1:0] it, input bit cv,
                      input logic [TW-1:0] ct, input bit dn);
    int            fi;
    bit            e_ext_vld;
    logic [TW-1:0] e_ext;
    logic [IW-1:0] e_cpl;
    bit            e_known;

    int_tag     = it;
    int_tag_vld = a;
    cpl_tag     = ct;
    cpl_tag_vld = cv;
    cpl_done    = dn;

    fi = -1;
    for (int i = 0; i < N; i++) begin
      if (!m_busy[i] && fi < 0) fi = i;
    end
    e_cpl     = m_map[ct];
    e_known   = m_known[ct];
    e_ext_vld = a && (fi >= 0);
    e_ext     = (fi >= 0) ? fi[TW-1:0] : '0;
    if (a && fi < 0) m_err = 1'b1;
    if (cv && dn) begin
      if (m_busy[ct]) begin
        m_busy[ct] = 1'b0;
        m_cnt--;
      end else begin
        m_err = 1'b1;
      end
    end
    if (e_ext_vld) begin
      m_busy[fi]  = 1'b1;
      m_map[fi]   = it;
      m_known[fi] = 1'b1;
      m_cnt++;
    end

    @(posedge clk);
    #1;
    drive_idle();

    check("ext_vld", ext_tag_vld, e_ext_vld);
    if (e_ext_vld) check("ext_tag", ext_tag, e_ext);
    check("cpl_vld", cpl_int_tag_vld, cv);
    if (cv && e_known) check("cpl_int_tag", cpl_int_tag, e_cpl);
    check("avail", tags_avail, (m_cnt < N));
    check("outstanding", tags_outstanding, m_cnt);
    check("err", tag_err, m_err);
  endtask

  initial begin
    int ct;
    bit found;
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    do_reset();

    // Fill the pool one pulse per cycle: tags come out 0..31 in order.
    for (int i = 0; i < N; i++) begin
      step(1'b1, IW'(i), 1'b0, '0, 1'b0);
      check("fill_ext_tag", ext_tag, i);
      check("fill_ext_vld", ext_tag_vld, 1);
    end
    check("full_avail", tags_avail, 0);
    check("full_outstanding", tags_outstanding, 32);

    // 33rd allocation against a full pool.
    step(1'b1, 6'h3F, 1'b0, '0, 1'b0);
    check("over_ext_vld", ext_tag_vld, 0);
    check("over_err", tag_err, 1);
    check("over_outstanding", tags_outstanding, 32);

    // Lookup without release keeps the tag busy.
    do_reset();
    step(1'b1, 6'h2A, 1'b0, '0, 1'b0);
    check("map_ext_tag", ext_tag, 0);
    step(1'b0, '0, 1'b1, 5'd0, 1'b0);
    check("map_cpl_int", cpl_int_tag, 6'h2A);
    check("map_still_busy", tags_outstanding, 1);
    step(1'b1, 6'h11, 1'b0, '0, 1'b0);
    check("map_next_tag", ext_tag, 1);

    // Simultaneous alloc and free: freed tag not eligible in that cycle.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, IW'(i + 8), 1'b0, '0, 1'b0);
    step(1'b1, 6'h20, 1'b1, 5'd1, 1'b1);
    check("swap_ext_tag", ext_tag, 4);
    check("swap_outstanding", tags_outstanding, 4);
    check("swap_cpl_int", cpl_int_tag, 9);
    step(1'b1, 6'h21, 1'b1, 5'd2, 1'b1);
    check("reuse_ext_tag", ext_tag, 1);
    check("reuse_outstanding", tags_outstanding, 4);

    // Alloc and lookup of the same tag in one cycle: lookup sees the old entry.
    step(1'b1, 6'h33, 1'b1, 5'd2, 1'b0);
    check("rw_ext_tag", ext_tag, 2);
    check("rw_old_entry", cpl_int_tag, 10);

    // Release of an idle tag.
    do_reset();
    step(1'b0, '0, 1'b1, 5'd7, 1'b1);
    check("idle_free_err", tag_err, 1);
    check("idle_free_outstanding", tags_outstanding, 0);
    step(1'b1, 6'h05, 1'b0, '0, 1'b0);
    check("idle_free_next", ext_tag, 0);

    // Mid-operation reset discards outstanding mappings.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, IW'(i), 1'b0, '0, 1'b0);
    check("pre_rst_outstanding", tags_outstanding, 10);
    do_reset();
    step(1'b1, 6'h01, 1'b0, '0, 1'b0);
    check("post_rst_ext_tag", ext_tag, 0);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        ct    = int'($urandom_range(0, N - 1));
        found = 1'b0;
        if ($urandom_range(0, 7) != 0) begin
          for (int k = 0; k < N; k++) begin
            if (!found && m_busy[(ct + k) % N]) begin
              ct    = (ct + k) % N;
              found = 1'b1;
            end
          end
        end
        step(($urandom_range(0, 2) != 0),
             IW'($urandom_range(0, 63)),
             ($urandom_range(0, 1) == 1),
             TW'(ct),
             ($urandom_range(0, 3) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
